// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with 3-sample majority vote,
// per-frame parity/framing/break status and a valid/ready receive FIFO.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | hunting for a start edge on the synchronised line
// START    | confirming the start bit; a high vote is a false start
// DATA     | shifting in len data bits, LSB first
// PARITY   | checking the optional parity bit
// STOP1    | first stop bit; single-stop frames and breaks push here
// STOP2    | second stop bit; two-stop frames push here
// BRK_WAIT | break received, waiting for the line to return high
module uart_rx_fifo #(
    parameter int OSR        = 16,
    parameter int MAX_W      = 9,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                i_rx_clk,
    input  logic                                rst,
    input  logic                                i_rx,
    input  logic                                i_rx_en,
    input  logic [3:0]                          i_len,
    input  logic                                i_parity_en,
    input  logic                                i_parity_ty,
    input  logic                                i_stop2,
    output logic [MAX_W-1:0]                    o_data,
    output logic                                o_perr,
    output logic                                o_ferr,
    output logic                                o_brk,
    output logic                                o_valid,
    input  logic                                i_ready,
    output logic                                o_overrun,
    input  logic                                i_clr_ovr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_count,
    output logic                                o_busy
);

    localparam int CW = $clog2(OSR);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = MAX_W + 3;

    localparam logic [CW-1:0] C_S0  = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] C_S1  = CW'(OSR / 2);
    localparam logic [CW-1:0] C_V   = CW'(OSR / 2 + 1);
    localparam logic [CW-1:0] C_END = CW'(OSR - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BRK_WAIT
    } state_t;

    state_t            state;
    logic              rx_meta;
    logic              rx_s;
    logic [CW-1:0]     cnt;
    logic [3:0]        bit_cnt;
    logic [3:0]        len_r;
    logic              par_en_r;
    logic              par_ty_r;
    logic              stop2_r;
    logic [MAX_W-1:0]  data_r;
    logic              perr_r;
    logic              ferr_r;
    logic              par_bit_r;
    logic              s0;
    logic              s1;
    logic              busy_r;

    logic [3:0]        len_eff;
    logic              vote;
    logic              at_vote;
    logic              brk_det;
    logic              push;
    logic              push_ferr;
    logic [EW-1:0]     push_entry;

    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [NW-1:0]     count;
    logic              ovr_r;
    logic              full;
    logic              pop;
    logic              push_ok;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge i_rx_clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // Clamp the requested word length into 5..MAX_W
    always_comb begin
        len_eff = i_len;
        if (i_len < 4'd5)
            len_eff = 4'd5;
        else if (i_len > 4'(MAX_W))
            len_eff = 4'(MAX_W);
    end

    // Majority vote and frame-push decision at the vote tick
    always_comb begin
        vote      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
        at_vote   = (cnt == C_V);
        brk_det   = (state == STOP1) && at_vote && !vote && (data_r == '0)
                    && (!par_en_r || !par_bit_r);
        push      = at_vote && (((state == STOP1) && (!stop2_r || brk_det))
                                || (state == STOP2));
        push_ferr = brk_det | !vote | ((state == STOP2) & ferr_r);
        if (brk_det)
            push_entry = {3'b110, {MAX_W{1'b0}}};
        else
            push_entry = {1'b0, push_ferr, perr_r, data_r};
    end

    // Receive FSM: bit timing, sampling, data assembly and status
    always_ff @(posedge i_rx_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            len_r     <= 4'd8;
            par_en_r  <= 1'b0;
            par_ty_r  <= 1'b0;
            stop2_r   <= 1'b0;
            data_r    <= '0;
            perr_r    <= 1'b0;
            ferr_r    <= 1'b0;
            par_bit_r <= 1'b0;
            s0        <= 1'b1;
            s1        <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            busy_r <= (state != IDLE);
            if (state != IDLE && state != BRK_WAIT) begin
                cnt <= (cnt == C_END) ? '0 : cnt + 1'b1;
                if (cnt == C_S0)
                    s0 <= rx_s;
                if (cnt == C_S1)
                    s1 <= rx_s;
            end
            case (state)
                IDLE: begin
                    if (i_rx_en && !rx_s) begin
                        state     <= START;
                        cnt       <= '0;
                        bit_cnt   <= '0;
                        len_r     <= len_eff;
                        par_en_r  <= i_parity_en;
                        par_ty_r  <= i_parity_ty;
                        stop2_r   <= i_stop2;
                        data_r    <= '0;
                        perr_r    <= 1'b0;
                        ferr_r    <= 1'b0;
                        par_bit_r <= 1'b0;
                    end
                end
                START: begin
                    if (at_vote && vote)
                        state <= IDLE;
                    else if (cnt == C_END)
                        state <= DATA;
                end
                DATA: begin
                    if (at_vote)
                        data_r <= data_r | (MAX_W'(vote) << bit_cnt);
                    if (cnt == C_END) begin
                        if (bit_cnt == len_r - 4'd1)
                            state <= par_en_r ? PARITY : STOP1;
                        else
                            bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                PARITY: begin
                    if (at_vote) begin
                        par_bit_r <= vote;
                        perr_r    <= (vote != (par_ty_r ? ^data_r : ~^data_r));
                    end
                    if (cnt == C_END)
                        state <= STOP1;
                end
                STOP1: begin
                    if (at_vote) begin
                        ferr_r <= !vote;
                        if (brk_det)
                            state <= BRK_WAIT;
                        else if (!stop2_r)
                            state <= IDLE;
                    end else if (cnt == C_END) begin
                        state <= STOP2;
                    end
                end
                STOP2: begin
                    if (at_vote)
                        state <= IDLE;
                end
                BRK_WAIT: begin
                    if (rx_s)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO handshake; a full FIFO still accepts a push when popped in the same cycle
    always_comb begin
        full    = (count == NW'(FIFO_DEPTH));
        pop     = (count != '0) && i_ready;
        push_ok = push && (!full || pop);
    end

    // FIFO storage, pointers, occupancy and sticky overrun
    always_ff @(posedge i_rx_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovr_r  <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)
                count <= count + 1'b1;
            else if (pop && !push_ok)
                count <= count - 1'b1;
            if (push && !push_ok)
                ovr_r <= 1'b1;
            else if (i_clr_ovr)
                ovr_r <= 1'b0;
        end
    end

    // Head entry is presented only while the FIFO holds data
    always_comb begin
        o_valid = (count != '0);
        if (o_valid)
            {o_brk, o_ferr, o_perr, o_data} = mem[rd_ptr];
        else
            {o_brk, o_ferr, o_perr, o_data} = '0;
        o_count   = count;
        o_overrun = ovr_r;
        o_busy    = busy_r;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo at OSR=16, MAX_W=9, FIFO_DEPTH=4.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       i_rx;
    logic       i_rx_en;
    logic [3:0] i_len;
    logic       i_parity_en;
    logic       i_parity_ty;
    logic       i_stop2;
    logic [8:0] o_data;
    logic       o_perr;
    logic       o_ferr;
    logic       o_brk;
    logic       o_valid;
    logic       i_ready;
    logic       o_overrun;
    logic       i_clr_ovr;
    logic [2:0] o_count;
    logic       o_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_fall  = 0;
    int t_rise  = 0;
    int busy_rises = 0;
    int busy_mark  = 0;
    logic valid_prev = 1'b0;
    logic busy_prev  = 1'b0;

    uart_rx_fifo #(.OSR(16), .MAX_W(9), .FIFO_DEPTH(4)) dut (
        .i_rx_clk   (clk),
        .rst        (rst),
        .i_rx       (i_rx),
        .i_rx_en    (i_rx_en),
        .i_len      (i_len),
        .i_parity_en(i_parity_en),
        .i_parity_ty(i_parity_ty),
        .i_stop2    (i_stop2),
        .o_data     (o_data),
        .o_perr     (o_perr),
        .o_ferr     (o_ferr),
        .o_brk      (o_brk),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_overrun  (o_overrun),
        .i_clr_ovr  (i_clr_ovr),
        .o_count    (o_count),
        .o_busy     (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Record o_valid rise time and count o_busy rises
    always @(negedge clk) begin
        if (o_valid && !valid_prev)
            t_rise = cyc;
        if (o_busy && !busy_prev)
            busy_rises = busy_rises + 1;
        valid_prev = o_valid;
        busy_prev  = o_busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one frame; gbit>=0 glitches that data bit at its centre,
    // pop_sync raises i_ready for exactly the stop-1 vote edge.
    task automatic send_frame(input logic [8:0] d, input int cfg_len, input int len,
                              input bit pen, input bit peven, input bit pbad,
                              input bit st2, input int gbit, input bit pop_sync);
        logic [15:0] fr;
        logic        p;
        int          nb;
        int          s1;
        i_len       = 4'(cfg_len);
        i_parity_en = pen;
        i_parity_ty = peven;
        i_stop2     = st2;
        fr = '0;
        p  = 1'b0;
        nb = 1;
        for (int i = 0; i < len; i++) begin
            fr[nb] = d[i];
            p      = p ^ d[i];
            nb++;
        end
        if (pen) begin
            fr[nb] = (peven ? p : ~p) ^ pbad;
            nb++;
        end
        s1 = nb;
        fr[nb] = 1'b1;
        nb++;
        if (st2) begin
            fr[nb] = 1'b1;
            nb++;
        end
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < 16; j++) begin
                @(posedge clk);
                #1;
                if (b == 0 && j == 0)
                    t_fall = cyc;
                i_rx = fr[b];
                if (b == gbit + 1 && j == 9)
                    i_rx = ~fr[b];
                if (pop_sync && b == s1 && j == 12)
                    i_ready = 1'b1;
                if (pop_sync && b == s1 && j == 13)
                    i_ready = 1'b0;
            end
        end
    endtask

    task automatic pop_one();
        @(posedge clk);
        #1 i_ready = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        i_rx = 1'b1;
        i_rx_en = 1'b1;
        i_len = 4'd8;
        i_parity_en = 1'b0;
        i_parity_ty = 1'b1;
        i_stop2 = 1'b0;
        i_ready = 1'b0;
        i_clr_ovr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", o_valid, 0);
        check("rst_count", o_count, 0);
        check("rst_data", o_data, 0);
        check("rst_flags", {o_brk, o_ferr, o_perr}, 0);
        check("rst_ovr", o_overrun, 0);
        check("rst_busy", o_busy, 0);
        rst = 1'b0;
        idle(5);

        // Basic 8N1 0xA5
        send_frame(9'h0A5, 8, 8, 0, 0, 0, 0, -1, 0);
        @(negedge clk);
        check("basic_lat", t_rise - t_fall, 157);
        check("basic_data", o_data, 9'h0A5);
        check("basic_flags", {o_brk, o_ferr, o_perr}, 0);
        check("basic_count", o_count, 1);
        check("basic_busy", o_busy, 0);
        pop_one();
        check("basic_pop", o_valid, 0);

        // 7E1 with bad parity, then a clean frame, then 8O1
        send_frame(9'h035, 7, 7, 1, 1, 1, 0, -1, 0);
        @(negedge clk);
        check("par_bad_data", o_data, 9'h035);
        check("par_bad_perr", o_perr, 1);
        check("par_bad_ferr", o_ferr, 0);
        pop_one();
        send_frame(9'h035, 7, 7, 1, 1, 0, 0, -1, 0);
        @(negedge clk);
        check("par_ok_data", o_data, 9'h035);
        check("par_ok_flags", {o_brk, o_ferr, o_perr}, 0);
        pop_one();
        send_frame(9'h05A, 8, 8, 1, 0, 0, 0, -1, 0);
        @(negedge clk);
        check("odd_ok_data", o_data, 9'h05A);
        check("odd_ok_perr", o_perr, 0);
        pop_one();

        // Length clamping: 2 acts as 5, 15 acts as 9
        send_frame(9'h015, 2, 5, 0, 0, 0, 0, -1, 0);
        @(negedge clk);
        check("len_lo_data", o_data, 9'h015);
        check("len_lo_ferr", o_ferr, 0);
        pop_one();
        send_frame(9'h155, 15, 9, 0, 0, 0, 0, -1, 0);
        @(negedge clk);
        check("len_hi_data", o_data, 9'h155);
        check("len_hi_ferr", o_ferr, 0);
        pop_one();

        // 3-cycle false start
        i_len = 4'd8; i_parity_en = 1'b0; i_stop2 = 1'b0;
        busy_mark = busy_rises;
        @(posedge clk);
        #1 i_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 i_rx = 1'b1;
        idle(40);
        check("false_busy_seen", busy_rises - busy_mark, 1);
        check("false_busy_low", o_busy, 0);
        check("false_count", o_count, 0);

        // Single-cycle glitch at the centre of data bit 2
        send_frame(9'h03C, 8, 8, 0, 0, 0, 0, 2, 0);
        @(negedge clk);
        check("glitch_data", o_data, 9'h03C);
        check("glitch_ferr", o_ferr, 0);
        pop_one();

        // Break: 8E1, line low for two frame times
        i_len = 4'd8; i_parity_en = 1'b1; i_parity_ty = 1'b1; i_stop2 = 1'b0;
        @(posedge clk);
        #1 i_rx = 1'b0;
        repeat (22 * 16) @(posedge clk);
        @(negedge clk);
        check("brk_count", o_count, 1);
        check("brk_flags", {o_brk, o_ferr}, 2'b11);
        check("brk_data", o_data, 0);
        check("brk_busy", o_busy, 1);
        @(posedge clk);
        #1 i_rx = 1'b1;
        idle(40);
        check("brk_after_count", o_count, 1);
        check("brk_after_busy", o_busy, 0);
        pop_one();
        check("brk_pop", o_valid, 0);

        // Overrun: five frames into a four-entry FIFO
        send_frame(9'h011, 8, 8, 0, 0, 0, 0, -1, 0);
        send_frame(9'h022, 8, 8, 0, 0, 0, 0, -1, 0);
        send_frame(9'h033, 8, 8, 0, 0, 0, 0, -1, 0);
        send_frame(9'h044, 8, 8, 0, 0, 0, 0, -1, 0);
        @(negedge clk);
        check("ovr_pre_flag", o_overrun, 0);
        send_frame(9'h055, 8, 8, 0, 0, 0, 0, -1, 0);
        @(negedge clk);
        check("ovr_count", o_count, 4);
        check("ovr_flag", o_overrun, 1);
        check("ovr_head", o_data, 9'h011);
        @(posedge clk);
        #1 i_clr_ovr = 1'b1;
        @(posedge clk);
        #1 i_clr_ovr = 1'b0;
        @(negedge clk);
        check("ovr_clr", o_overrun, 0);
        send_frame(9'h066, 8, 8, 0, 0, 0, 0, -1, 1);
        @(negedge clk);
        check("sync_count", o_count, 4);
        check("sync_ovr", o_overrun, 0);
        check("sync_head1", o_data, 9'h022);
        pop_one();
        check("sync_head2", o_data, 9'h033);
        pop_one();
        check("sync_head3", o_data, 9'h044);
        pop_one();
        check("sync_head4", o_data, 9'h066);
        pop_one();
        check("sync_empty", o_count, 0);

        // Reset during the 4th data bit, with an entry already queued
        send_frame(9'h05A, 8, 8, 0, 0, 0, 0, -1, 0);
        @(negedge clk);
        check("mid_pre_count", o_count, 1);
        @(posedge clk);
        #1 i_rx = 1'b0;
        repeat (16) @(posedge clk);
        #1 i_rx = 1'b1;
        repeat (3 * 16 + 8) @(posedge clk);
        @(negedge clk);
        check("mid_busy", o_busy, 1);
        rst = 1'b1;
        #2;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_count", o_count, 0);
        check("mid_rst_data", o_data, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_ovr", o_overrun, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(40);
        check("mid_post_count", o_count, 0);
        check("mid_post_busy", o_busy, 0);
        send_frame(9'h1C3, 9, 9, 0, 0, 0, 1, -1, 0);
        @(negedge clk);
        check("n92_lat", t_rise - t_fall, 189);
        check("n92_data", o_data, 9'h1C3);
        check("n92_flags", {o_brk, o_ferr, o_perr}, 0);
        pop_one();
        check("n92_pop", o_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised oversampling UART receiver with majority-vote bit sampling and a receive FIFO. It sits between the asynchronous serial line and the system-side consumer. It is the next-generation receiver and adds:
- configurable oversample ratio and data width (5..MAX_W bits);
- separate parity, framing and break status per frame;
- mid-stop-bit resynchronisation;
- a valid/ready FIFO output with overrun detection.

## Interface
Parameters:
- OSR, 16, oversample clocks per bit; even, ≥ 8.
- MAX_W, 9, maximum data bits per frame; 5..9.
- FIFO_DEPTH, 4, receive FIFO entries; power of 2, ≥ 2.

Ports:
- i_rx_clk  in  1  sole clock, OSR × baud rate.
- rst  in  1  reset, asynchronous, active-high.
- i_rx  in  1  serial line, asynchronous, idles high.
- i_rx_en  in  1  receiver enable, sampled only in IDLE.
- i_len  in  4  data bits per frame; values < 5 act as 5, values > MAX_W act as MAX_W.
- i_parity_en  in  1  a parity bit follows the data.
- i_parity_ty  in  1  1 = even parity, 0 = odd parity.
- i_stop2  in  1  two stop bits.
- o_data  out  MAX_W  data of the FIFO head entry, LSB-aligned, unused upper bits 0.
- o_perr  out  1  parity error flag of the head entry.
- o_ferr  out  1  framing error flag of the head entry.
- o_brk  out  1  break flag of the head entry.
- o_valid  out  1  FIFO not empty.
- i_ready  in  1  consumer accepts the head entry.
- o_overrun  out  1  sticky flag: a frame was dropped because the FIFO was full.
- i_clr_ovr  in  1  clears o_overrun.
- o_count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- o_busy  out  1  FSM is not in IDLE.

## Operation
- **Input synchroniser:** i_rx passes through 2 flops (reset value 1); rx_s is the synchronised line. All FSM decisions use rx_s.
- **Frame configuration:** i_len, i_parity_en, i_parity_ty and i_stop2 are latched on entry to START. Changes mid-frame have no effect.
- **Bit timing:** tick counter cnt runs 0..OSR-1 within each bit. rx_s is sampled at cnt = OSR/2-1, OSR/2 and OSR/2+1. The bit value is the majority of the three samples and takes effect at cnt = OSR/2+1.
- **States:**
  - IDLE: when i_rx_en=1 and rx_s=0, go to START with cnt=0.
  - START: voted bit = 1 is a false start; return to IDLE and push nothing. At cnt=OSR-1, go to DATA.
  - DATA: voted bit goes into data[bit_cnt], LSB first. After len bits, at cnt=OSR-1, go to PARITY if enabled, otherwise STOP1.
  - PARITY: perr = (voted bit ≠ expected). Expected bit = ^data for even parity, ~^data for odd parity. At cnt=OSR-1, go to STOP1.
  - STOP1: ferr = (voted bit = 0). With i_stop2, go to STOP2 at cnt=OSR-1. Without i_stop2, push the frame at the vote and go to IDLE on the next edge (mid-stop resync).
  - STOP2: ferr |= (voted bit = 0). Push at the vote, then go to IDLE.
  - BRK_WAIT: wait for rx_s=1, then go to IDLE.
- **Break:** all data bits 0, parity bit 0 (if enabled) and stop1 0 together mean a break. The frame is pushed with brk=1, ferr=1, data=0, and the FSM goes to BRK_WAIT instead of IDLE. STOP2 is skipped.
- **FIFO entry:** {brk, ferr, perr, data}.
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the frame is discarded and o_overrun is set. FIFO contents are unchanged.
- **Pop:** occurs on the edge where o_valid & i_ready. Outputs present the new head on the next cycle.
- **o_overrun:** setting the flag has priority over i_clr_ovr in the same cycle.
- **i_rx_en:** deasserting it mid-frame does not abort the frame.

## Timing
- **Reset values:** o_data=0, o_perr/o_ferr/o_brk=0, o_valid=0, o_overrun=0, o_count=0, o_busy=0. FSM goes to IDLE, counters clear, FIFO is emptied, synchroniser flops are set to 1.
- **Reset mid-frame:** the partial frame is discarded and nothing is pushed.
- **Latency:** o_valid rises (1 + len + parity_en + stop2) × OSR + OSR/2 + 5 cycles after the i_rx falling edge of the start bit. For 8N1 at OSR=16 this is 157 cycles.
- **Back-to-back frames:** the receiver hunts for the next start bit from the cycle after the last stop vote. A start edge arriving OSR/2-2 cycles after the nominal stop centre is captured.
- **o_count:** updates on the same edge as the push or pop. A simultaneous push and pop leaves it unchanged.
- **o_busy:** high from the cycle after START entry until the cycle after return to IDLE.

## Test plan
- **Basic frame:** 8N1 0xA5 at OSR=16 → o_data=0x0A5, all error flags 0, o_valid rises 157 cycles after the falling edge; i_ready=1 then drops o_valid.
- **Parity error:** 7E1 data 0x35 with a wrong parity bit → o_data=0x035, o_perr=1, o_ferr=0; the next frame is correct and clean.
- **Glitches:** start-bit low pulse of 3 cycles → no push, o_busy returns to 0. A 1-cycle inverted glitch at cnt=8 inside a data bit → data still correct.
- **Break:** line held low for 2 frame times with 8E1 → one entry with o_brk=1, o_ferr=1, o_data=0. No further push until the line returns high.
- **Overrun:** i_ready=0 and 5 frames at FIFO_DEPTH=4 → o_count=4, o_overrun=1, the first 4 entries are intact in order. i_clr_ovr clears the flag. A push coinciding with a pop while full is accepted.
- **Reset mid-frame:** assert rst during the 4th data bit → all outputs at reset values. A subsequent 9-bit 2-stop-bit frame 0x1C3 is received as o_data=0x1C3.
